// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one registered 8x16 2bpp tile shifter between NUM_REQ requesters.
// Optional macro SHIFT_IDENTITY_BYPASS_EN: zero-magnitude shifts skip the shifter (1-cycle response).
module shifter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_img,
  input  logic [NUM_REQ*5-1:0]   req_offset_x,
  input  logic [NUM_REQ*5-1:0]   req_offset_y,
  output logic                   sh_clk_en,
  output logic [4:0]             sh_offset_x,
  output logic [4:0]             sh_offset_y,
  output logic [127:0]           sh_img,
  input  logic [127:0]           sh_shifted,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [127:0]           rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [ID_W-1:0]   id_q, id_d;
  logic [127:0]      img_q, img_d;
  logic [4:0]        offx_q, offx_d;
  logic [4:0]        offy_q, offy_d;

  logic [127:0]      img_arr  [NUM_REQ];
  logic [4:0]        offx_arr [NUM_REQ];
  logic [4:0]        offy_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign img_arr[gi]  = req_img[gi*128 +: 128];
    assign offx_arr[gi] = req_offset_x[gi*5 +: 5];
    assign offy_arr[gi] = req_offset_y[gi*5 +: 5];
  end

`ifdef SHIFT_IDENTITY_BYPASS_EN
  logic         byp_q, byp_d;
  logic [127:0] byp_data_q, byp_data_d;
  logic         identity;
  assign identity = (offx_arr[grant_idx][3:0] == 4'd0) && (offy_arr[grant_idx][3:0] == 4'd0);
`endif

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_p;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_p     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!grant_any && req_valid[idx_p]) begin
        grant_any = 1'b1;
        grant_idx = idx_p;
      end
    end
  end

  // The shifter sees the latched request; these hold between grants.
  assign sh_img      = img_q;
  assign sh_offset_x = offx_q;
  assign sh_offset_y = offy_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    img_d     = img_q;
    offx_d    = offx_q;
    offy_d    = offy_q;
    req_ready = '0;
    sh_clk_en = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
`ifdef SHIFT_IDENTITY_BYPASS_EN
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_any && !rst) begin
          req_ready[grant_idx] = 1'b1;
          id_d     = ID_W'(grant_idx);
          img_d    = img_arr[grant_idx];
          offx_d   = offx_arr[grant_idx];
          offy_d   = offy_arr[grant_idx];
          rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
          state_d  = S_ISSUE;
`ifdef SHIFT_IDENTITY_BYPASS_EN
          byp_d      = identity;
          byp_data_d = img_arr[grant_idx];
          if (identity) state_d = S_RESP;
`endif
        end
      end
      S_ISSUE: begin
        sh_clk_en = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
`ifdef SHIFT_IDENTITY_BYPASS_EN
        rsp_data  = byp_q ? byp_data_q : sh_shifted;
`else
        rsp_data  = sh_shifted;
`endif
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      img_q    <= '0;
      offx_q   <= '0;
      offy_q   <= '0;
`ifdef SHIFT_IDENTITY_BYPASS_EN
      byp_q      <= 1'b0;
      byp_data_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      img_q    <= img_d;
      offx_q   <= offx_d;
      offy_q   <= offy_d;
`ifdef SHIFT_IDENTITY_BYPASS_EN
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed testbench for shifter_arbiter with a behavioural clock-enabled tile shifter attached.
module tb_shifter_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req_valid = '0;
  logic [3:0]     req_ready;
  logic [511:0]   req_img = '0;
  logic [19:0]    req_offset_x = '0;
  logic [19:0]    req_offset_y = '0;
  logic           sh_clk_en;
  logic [4:0]     sh_offset_x;
  logic [4:0]     sh_offset_y;
  logic [127:0]   sh_img;
  logic [127:0]   sh_shifted = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [127:0]   rsp_data;

  int checks = 0;
  int errors = 0;

  shifter_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_img(req_img),
    .req_offset_x(req_offset_x), .req_offset_y(req_offset_y),
    .sh_clk_en(sh_clk_en), .sh_offset_x(sh_offset_x), .sh_offset_y(sh_offset_y),
    .sh_img(sh_img), .sh_shifted(sh_shifted),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Shifter: x moves 2-bit pixels within each 16-bit row (bit4 = right), y moves whole rows (bit4 = down).
  function automatic logic [127:0] shift_tile(input logic [127:0] img, input logic [4:0] ox, input logic [4:0] oy);
    logic [127:0] r;
    logic [15:0]  v;
    r = '0;
    for (int row = 0; row < 8; row++) begin
      v = img[row*16 +: 16];
      v = ox[4] ? (v >> (2 * ox[3:0])) : (v << (2 * ox[3:0]));
      r[row*16 +: 16] = v;
    end
    return oy[4] ? (r >> (16 * oy[3:0])) : (r << (16 * oy[3:0]));
  endfunction

  always @(posedge clk) begin
    if (sh_clk_en) sh_shifted <= shift_tile(sh_img, sh_offset_x, sh_offset_y);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [127:0] img, input logic [4:0] ox, input logic [4:0] oy);
    req_img[i*128 +: 128] = img;
    req_offset_x[i*5 +: 5] = ox;
    req_offset_y[i*5 +: 5] = oy;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    tick;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if ({sh_clk_en, sh_offset_x, sh_offset_y} !== 11'd0) begin errors++; $display("FAIL reset_sh_ctrl: got %b want 0", {sh_clk_en, sh_offset_x, sh_offset_y}); end
    checks++; if (sh_img !== 128'd0) begin errors++; $display("FAIL reset_sh_img: got %h want 0", sh_img); end
    checks++; if ({rsp_valid, rsp_id} !== 3'd0) begin errors++; $display("FAIL reset_rsp_ctrl: got %b want 000", {rsp_valid, rsp_id}); end
    checks++; if (rsp_data !== 128'd0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    req_valid = '0;
    $display("txn reset: outputs checked while rst high");
  endtask

  task automatic test_single;
    do_reset;
    rsp_ready = 1'b1;
    set_req(0, 128'h1, 5'h01, 5'h00);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready_T: got %b want 0001", req_ready); end
    checks++; if (sh_clk_en !== 1'b0) begin errors++; $display("FAIL single_clk_en_T: got %b want 0", sh_clk_en); end
    tick;
    req_valid = '0;
    checks++; if (sh_clk_en !== 1'b1) begin errors++; $display("FAIL single_clk_en_T1: got %b want 1", sh_clk_en); end
    checks++; if ({req_ready, rsp_valid} !== 5'd0) begin errors++; $display("FAIL single_idle_T1: got %b want 0", {req_ready, rsp_valid}); end
    checks++; if (sh_img !== 128'h1 || sh_offset_x !== 5'h01 || sh_offset_y !== 5'h00) begin errors++; $display("FAIL single_sh_inputs: got img=%h x=%h y=%h want 1/01/00", sh_img, sh_offset_x, sh_offset_y); end
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_T2: got valid=%b id=%0d want 1/0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 128'h4) begin errors++; $display("FAIL single_data: got %h want 4", rsp_data); end
    checks++; if (sh_clk_en !== 1'b0) begin errors++; $display("FAIL single_clk_en_T2: got %b want 0", sh_clk_en); end
    $display("txn single: id=%0d data=%h", rsp_id, rsp_data);
    tick;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_after: got rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_offsets;
    do_reset;
    rsp_ready = 1'b1;
    set_req(2, 128'h1, 5'h00, 5'h01);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL offy_ready: got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 128'h10000) begin errors++; $display("FAIL offy_rsp: got v=%b id=%0d data=%h want 1/2/10000", rsp_valid, rsp_id, rsp_data); end
    $display("txn offy: id=%0d data=%h", rsp_id, rsp_data);
    tick;
    set_req(2, 128'h4, 5'h11, 5'h00);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL offx_ready: got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 128'h1) begin errors++; $display("FAIL offx_right_rsp: got v=%b id=%0d data=%h want 1/2/1", rsp_valid, rsp_id, rsp_data); end
    $display("txn offx_right: id=%0d data=%h", rsp_id, rsp_data);
    tick;
  endtask

  task automatic test_round_robin;
    int g;
    do_reset;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 128'(i + 1), 5'h01, 5'h00);
    #1;
    for (int c = 0; c < 15; c++) begin
      g = (c / 3) % 4;
      if (c % 3 == 0) begin
        checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << g)); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_no_grant c=%0d: got %b want 0000", c, req_ready); end
      end
      if (c % 3 == 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== 128'((g + 1) * 4)) begin errors++; $display("FAIL rr_rsp c=%0d: got v=%b id=%0d data=%h want 1/%0d/%0h", c, rsp_valid, rsp_id, rsp_data, g, (g + 1) * 4); end
        $display("txn rr: id=%0d data=%h", rsp_id, rsp_data);
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_idle c=%0d: got %b want 0", c, rsp_valid); end
      end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    rsp_ready = 1'b0;
    set_req(1, 128'h30, 5'h12, 5'h00);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready: got %b want 0010", req_ready); end
    tick;
    req_valid[1] = 1'b0;
    set_req(3, 128'h5, 5'h01, 5'h00);
    tick;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 128'h3) begin errors++; $display("FAIL bp_hold c=%0d: got v=%b id=%0d data=%h want 1/1/3", c, rsp_valid, rsp_id, rsp_data); end
      checks++; if (sh_clk_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_quiet c=%0d: got clk_en=%b ready=%b want 0/0000", c, sh_clk_en, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 128'h3) begin errors++; $display("FAIL bp_transfer: got v=%b data=%h want 1/3", rsp_valid, rsp_data); end
    $display("txn backpressure: id=%0d data=%h", rsp_id, rsp_data);
    tick;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin errors++; $display("FAIL bp_back_idle: got v=%b ready=%b want 0/1000", rsp_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    rsp_ready = 1'b1;
    set_req(1, 128'h7, 5'h01, 5'h01);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ready1: got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({sh_clk_en, sh_offset_x, sh_offset_y, req_ready, rsp_valid} !== 16'd0) begin errors++; $display("FAIL rmid_issue_ctrl: got %b want 0", {sh_clk_en, sh_offset_x, sh_offset_y, req_ready, rsp_valid}); end
    checks++; if (sh_img !== 128'd0) begin errors++; $display("FAIL rmid_issue_img: got %h want 0", sh_img); end
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (rsp_valid !== 1'b0 || sh_clk_en !== 1'b0) begin errors++; $display("FAIL rmid_silent1 c=%0d: got v=%b en=%b want 0/0", c, rsp_valid, sh_clk_en); end
      tick;
    end
    set_req(1, 128'h7, 5'h01, 5'h01);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ready2: got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_resp_reached: got %b want 1", rsp_valid); end
    rst = 1'b1;
    #1;
    checks++; if ({rsp_valid, rsp_id} !== 3'd0 || rsp_data !== 128'd0) begin errors++; $display("FAIL rmid_resp_clear: got v=%b id=%0d data=%h want 0/0/0", rsp_valid, rsp_id, rsp_data); end
    tick;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_silent2 c=%0d: got %b want 0", c, rsp_valid); end
      tick;
    end
    set_req(0, 128'h1, 5'h01, 5'h00);
    set_req(2, 128'h1, 5'h01, 5'h00);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr_reset: got %b want 0001", req_ready); end
    $display("txn reset_mid: next grant ready=%b", req_ready);
    req_valid = '0;
  endtask

  task automatic test_identity;
    do_reset;
    rsp_ready = 1'b1;
    set_req(0, 128'hDEAD, 5'h10, 5'h10);
    #1;
    checks++; if (req_ready !== 4'b0001 || sh_clk_en !== 1'b0) begin errors++; $display("FAIL ident_T: got ready=%b en=%b want 0001/0", req_ready, sh_clk_en); end
    tick;
    req_valid = '0;
`ifdef SHIFT_IDENTITY_BYPASS_EN
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 128'hDEAD || rsp_id !== 2'd0) begin errors++; $display("FAIL ident_byp_rsp: got v=%b data=%h id=%0d want 1/dead/0", rsp_valid, rsp_data, rsp_id); end
    checks++; if (sh_clk_en !== 1'b0) begin errors++; $display("FAIL ident_byp_en: got %b want 0", sh_clk_en); end
    $display("txn identity_bypass: id=%0d data=%h", rsp_id, rsp_data);
    tick;
    checks++; if (rsp_valid !== 1'b0 || sh_clk_en !== 1'b0) begin errors++; $display("FAIL ident_byp_after: got v=%b en=%b want 0/0", rsp_valid, sh_clk_en); end
`else
    checks++; if (sh_clk_en !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ident_T1: got en=%b v=%b want 1/0", sh_clk_en, rsp_valid); end
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 128'hDEAD || sh_clk_en !== 1'b0) begin errors++; $display("FAIL ident_T2: got v=%b data=%h en=%b want 1/dead/0", rsp_valid, rsp_data, sh_clk_en); end
    $display("txn identity: id=%0d data=%h", rsp_id, rsp_data);
    tick;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ident_after: got %b want 0", rsp_valid); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_offsets;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
    test_identity;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one tile shifter (8 rows x 16 bit, 2 bpp, 1-cycle registered, clock-enabled) between NUM_REQ requesters, typically sprite/background fetch channels in the video path.
- Arbitrates round-robin, latches the winning request, and drives the shifter's clk_en/offset/img inputs for exactly one cycle.
- Returns the shifted tile, tagged with the requester index, over a valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot pulse
- req_img  input  NUM_REQ*128  tile per requester; slice i at [i*128 +: 128]
- req_offset_x  input  NUM_REQ*5  x offset per requester; bit4 = right, [3:0] = pixels
- req_offset_y  input  NUM_REQ*5  y offset per requester; bit4 = down, [3:0] = rows
- sh_clk_en  output  1  shifter clock enable
- sh_offset_x  output  5  shifter x offset
- sh_offset_y  output  5  shifter y offset
- sh_img  output  128  shifter input tile
- sh_shifted  input  128  shifter registered output
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted by consumer
- rsp_id  output  ID_W  index of the served requester
- rsp_data  output  128  shifted tile

Behaviour:
Reset:
- While rst is high (asynchronous): state=IDLE, rr_ptr=0, all outputs 0 (req_ready, sh_clk_en, sh_offset_x/y, sh_img, rsp_valid, rsp_id, rsp_data).
- Reset mid-operation discards any latched request or pending response; no response is emitted for it.

Handshake:
- A request transfers when req_valid[i] and req_ready[i] are both high.
- Requesters hold valid and payload stable until accepted. Withdrawing a request is illegal.
- Response transfers when rsp_valid and rsp_ready are both high.

Arbitration:
- Round-robin. Search starts at rr_ptr and wraps modulo NUM_REQ.
- On a grant to requester g: rr_ptr <= (g+1) mod NUM_REQ; with g = NUM_REQ-1, rr_ptr wraps to 0.
- Requests that are not granted stay pending with no side effect.

FSM:
- IDLE:
  - If any req_valid: req_ready[g] is asserted combinationally this cycle; latch the payload and g into internal registers; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - sh_clk_en=1; sh_offset_x, sh_offset_y, sh_img driven from the latched registers.
  - Always go to RESP.
- RESP:
  - rsp_valid=1, rsp_data=sh_shifted, rsp_id=latched g.
  - sh_clk_en=0, so the shifter output holds.
  - Stay in RESP while rsp_ready=0; data and id stay stable.
  - On rsp_ready=1: go to IDLE. A new grant can occur on the following cycle.
  - No request is accepted while in ISSUE or RESP.
- Outside ISSUE, sh_clk_en=0. sh_* data outputs keep their last values.

Latency and throughput:
- Accept at cycle T, sh_clk_en at T+1, rsp_valid at T+2.
- Minimum 3 cycles per transaction.

Simultaneous events:
- All requesters valid with rr_ptr=0: grants go 0,1,2,3,0,...
- Requests arriving during RESP wait until IDLE.

Widths:
- Offsets are passed through unmodified; the shifter interprets sign bit and magnitude.
- rsp_id is zero-extended to ID_W.

Optional Feature:
- Macro: SHIFT_IDENTITY_BYPASS_EN
- Defined:
  - In IDLE, if the granted request has offset_x[3:0]==0 and offset_y[3:0]==0 (either sign bit), skip ISSUE.
  - Load rsp_data from req_img of the grant into a bypass register; go directly to RESP with rsp_data taken from that register. Response latency is 1 cycle.
  - sh_clk_en stays 0 for bypassed requests.
- Undefined: every request goes through ISSUE; latency is always 2 cycles.

Test Plan:
1. Single requester 0: img=128'h1, offset_x=5'h01, offset_y=0 -> req_ready[0] at T; sh_clk_en only at T+1; rsp_valid at T+2 with rsp_data=128'h4, rsp_id=0.
2. Requester 2: img=128'h1, offset_x=0, offset_y=5'h01 -> rsp_data=128'h10000, rsp_id=2. Then img=128'h4, offset_x=5'h11 -> rsp_data=128'h1.
3. All four req_valid held high from reset, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Exactly one req_ready bit per grant; new grants spaced 3 cycles apart.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable, sh_clk_en=0, no req_ready. On rsp_ready=1, one transfer, then IDLE.
5. Assert rst in ISSUE and again in RESP -> all outputs 0 immediately; no rsp_valid after release; the next grant goes to requester 0.
6. With SHIFT_IDENTITY_BYPASS_EN: offset_x=5'h10, offset_y=5'h10, img=128'hDEAD -> rsp_valid at T+1, rsp_data=128'hDEAD, sh_clk_en never high. Without the macro: same stimulus -> rsp_valid at T+2, sh_clk_en pulse at T+1.
